audio_stream_pio: RTL and testbench
===================================

AUDIO_STREAM_PIO -- requirements
Module: audio_stream_pio

Interface
REQ-001 SHALL have parameter DATA_W, default 32: sample width, 1..32.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO entries, power of two, 2..256.
REQ-003 SHALL have parameter DIV_RESET, default 1041: divider reset value (48 kHz at 50 MHz).
REQ-004 SHALL have parameter LOW_WM, default 4: level at or below which the interrupt asserts.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port address, input, 2: Avalon-MM word address.
REQ-008 SHALL have port chipselect, input, 1: slave select.
REQ-009 SHALL have port write_n, input, 1: active-low write strobe.
REQ-010 SHALL have port writedata, input, 32: write data.
REQ-011 SHALL have port readdata, output, 32: read data, zero wait states, combinational from address.
REQ-012 SHALL have port out_port, output, DATA_W: current audio sample to the codec.
REQ-013 SHALL have port sample_strobe, output, 1: one-cycle pulse on each sample tick.
REQ-014 SHALL have port irq, output, 1: level-low interrupt.

Function
REQ-015 SHALL decode address 0 as DATA: write pushes writedata[DATA_W-1:0]; read returns out_port zero-extended.
REQ-016 SHALL decode address 1 as STATUS: bit0 empty, bit1 full, bit2 underrun, bit3 overflow, bits[31:16] level; writing 1 to bit2 or bit3 clears that bit.
REQ-017 SHALL decode address 2 as CONTROL: bit0 enable, bit1 flush (self-clearing, reads 0), bit2 irq_en.
REQ-018 SHALL decode address 3 as DIVIDER: 16-bit tick period minus one; bits[31:16] read 0.
REQ-019 SHALL define a write as chipselect=1 and write_n=0, with an effect one cycle later.
REQ-020 SHALL, while enable=1, count 0..DIVIDER; at DIVIDER it SHALL issue a tick and wrap to 0.
REQ-021 SHALL tick every cycle when DIVIDER=0.
REQ-022 SHALL hold the counter at 0 when enable=0.
REQ-023 SHALL reset the counter to 0 on a DIVIDER write.
REQ-024 SHALL, on a tick with the FIFO non-empty, pop the head into out_port and pulse sample_strobe in the same cycle the out_port register updates.
REQ-025 SHALL, on a tick with the FIFO empty, hold out_port, set underrun, and still pulse sample_strobe.
REQ-026 SHALL drop a DATA write when full, leave FIFO contents unchanged, and set overflow.
REQ-027 SHALL, on a simultaneous push and pop with the FIFO non-empty, perform both and leave the level unchanged.
REQ-028 SHALL, on a simultaneous push and pop with the FIFO empty, not bypass: the push is stored, underrun is set, and out_port is held.
REQ-029 SHALL accept a push when full if a pop occurs in the same cycle, with no overflow.
REQ-030 SHALL, on flush, empty the FIFO (level 0) without changing out_port, the sticky bits or the counter.
REQ-031 SHALL make flush win over a push or pop in the same cycle.
REQ-032 SHALL drive irq = irq_en AND enable AND (level <= LOW_WM), registered.
REQ-033 SHALL wrap FIFO pointers modulo DEPTH and hold the level in clog2(DEPTH)+1 bits.

Reset
REQ-034 SHALL, on reset, set out_port=0, readdata=0 at address 0, sample_strobe=0, irq=0, level=0, both sticky bits=0, enable=0, irq_en=0, DIVIDER=DIV_RESET and counter=0.
REQ-035 SHALL, when reset is asserted mid-stream, take priority over every write or tick in that cycle.
REQ-036 SHALL leave FIFO RAM contents unreset, as they are don't-care.

Structure
REQ-037 SHALL place register address constants (DATA, STATUS, CONTROL, DIVIDER), status and control bit positions, and the level field offset in shared package audio_pio_pkg.
REQ-038 SHALL instantiate one sub-module, audio_sync_fifo (parameters DATA_W, DEPTH; ports push, pop, flush, full, empty, level); the tick counter and register file stay in the top level.

Verification
REQ-039 SHALL verify: reset, write DIVIDER=3, push 0x11,0x22, write CONTROL=1 -> out_port 0x11 then 0x22 at 4-cycle spacing, strobe with each, level 2->1->0.
REQ-040 SHALL verify: DEPTH=16, 17 DATA writes with enable=0 -> full=1, level=16, overflow=1, 17th value absent from later pops.
REQ-041 SHALL verify: enable with an empty FIFO, DIVIDER=0 -> underrun=1 after first tick, out_port stays 0; STATUS write 0x4 -> underrun=0.
REQ-042 SHALL verify: full FIFO with DIVIDER=0, push on a tick cycle -> accepted, level stays 16, overflow=0.
REQ-043 SHALL verify: level 8, CONTROL=0x7 (flush|enable|irq_en) -> level 0, out_port unchanged, irq=1 next cycle; pushes up to level 5 -> irq=0.
REQ-044 SHALL verify: assert reset mid-stream during a tick plus push -> all REQ-034 values next cycle, DIVIDER reads 1041.

Source files
------------

// File: rtl/audio_pio_pkg.sv
// Shared register map and bit positions for the audio stream PIO.
// Used by the top level register file and by the testbench.
package audio_pio_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_DIVIDER = 2'd3
  } reg_addr_e;

  localparam int STAT_EMPTY_BIT    = 0;
  localparam int STAT_FULL_BIT     = 1;
  localparam int STAT_UNDERRUN_BIT = 2;
  localparam int STAT_OVERFLOW_BIT = 3;
  localparam int STAT_LEVEL_LSB    = 16;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int DIV_W = 16;

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock sample FIFO with a registered head output.
// The head register only moves on an accepted pop, so it doubles as the codec sample.
module audio_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_push;
  logic              w_pop;

  assign empty = (r_level == '0);
  assign full  = (r_level == LVL_W'(DEPTH));
  assign level = r_level;
  assign rd_data = r_rd_data;

  // No bypass: a pop needs stored data; a full FIFO still takes a push if it pops.
  assign w_pop  = pop && !empty && !flush;
  assign w_push = push && (!full || w_pop) && !flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_rd_data <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/audio_stream_pio.sv
// Avalon-MM audio output PIO: register file, sample-rate divider and FIFO feeding the codec.
// Each divider tick pops one sample into out_port and pulses sample_strobe.
module audio_stream_pio
  import audio_pio_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int DIV_RESET = 1041,
  parameter int LOW_WM    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              sample_strobe,
  output logic              irq
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RESET);

  logic             r_enable;
  logic             r_irq_en;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_count;
  logic             r_underrun;
  logic             r_overflow;
  logic             r_strobe;
  logic             r_irq;

  logic             w_wr;
  logic             w_wr_data;
  logic             w_wr_status;
  logic             w_wr_ctrl;
  logic             w_wr_div;
  logic             w_flush;
  logic             w_tick;
  logic             w_full;
  logic             w_empty;
  logic [LVL_W-1:0] w_level;
  logic [31:0]      w_rdata;
  logic             w_unused_wdata;

  assign w_wr        = chipselect && !write_n;
  assign w_wr_data   = w_wr && (address == REG_DATA);
  assign w_wr_status = w_wr && (address == REG_STATUS);
  assign w_wr_ctrl   = w_wr && (address == REG_CONTROL);
  assign w_wr_div    = w_wr && (address == REG_DIVIDER);
  assign w_flush     = w_wr_ctrl && writedata[CTRL_FLUSH_BIT];
  assign w_tick      = r_enable && (r_count == r_div);
  assign w_unused_wdata = ^writedata;

  audio_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_wr_data),
    .pop     (w_tick),
    .flush   (w_flush),
    .wr_data (writedata[DATA_W-1:0]),
    .rd_data (out_port),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_wr_div || !r_enable || w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable <= 1'b0;
      r_irq_en <= 1'b0;
      r_div    <= DIV_INIT;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= writedata[CTRL_ENABLE_BIT];
        r_irq_en <= writedata[CTRL_IRQ_EN_BIT];
      end
      if (w_wr_div) begin
        r_div <= writedata[DIV_W-1:0];
      end
    end
  end

  // A new event outranks a software clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_tick && w_empty) begin
        r_underrun <= 1'b1;
      end else if (w_wr_status && writedata[STAT_UNDERRUN_BIT]) begin
        r_underrun <= 1'b0;
      end
      if (w_wr_data && w_full && !w_tick && !w_flush) begin
        r_overflow <= 1'b1;
      end else if (w_wr_status && writedata[STAT_OVERFLOW_BIT]) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_strobe <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_strobe <= w_tick;
      r_irq    <= r_irq_en && r_enable && (int'(w_level) <= LOW_WM);
    end
  end

  assign sample_strobe = r_strobe;
  assign irq           = r_irq;

  always_comb begin
    w_rdata = '0;
    case (address)
      REG_DATA: begin
        w_rdata[DATA_W-1:0] = out_port;
      end
      REG_STATUS: begin
        w_rdata[STAT_EMPTY_BIT]    = w_empty;
        w_rdata[STAT_FULL_BIT]     = w_full;
        w_rdata[STAT_UNDERRUN_BIT] = r_underrun;
        w_rdata[STAT_OVERFLOW_BIT] = r_overflow;
        w_rdata[STAT_LEVEL_LSB +: LVL_W] = w_level;
      end
      REG_CONTROL: begin
        w_rdata[CTRL_ENABLE_BIT] = r_enable;
        w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
      end
      default: begin
        w_rdata[DIV_W-1:0] = r_div;
      end
    endcase
  end

  assign readdata = w_rdata;

endmodule

// File: tb/tb_audio_stream_pio.sv
// Scoreboard bench for audio_stream_pio: stimulus queues expectations, one monitor compares.
module tb_audio_stream_pio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic        sample_strobe;
  logic        irq;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_DIV  = 2'd3;

  localparam int S_RDATA  = 0;
  localparam int S_OUT    = 1;
  localparam int S_IRQ    = 2;
  localparam int S_STROBE = 3;
  localparam int S_SBQ    = 4;

  audio_stream_pio dut (
    .clk           (clk),
    .reset         (reset),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .out_port      (out_port),
    .sample_strobe (sample_strobe),
    .irq           (irq)
  );

  always #50 clk = ~clk;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        chk_q[$];
  logic [31:0] sb_q[$];
  bit          sb_en = 1'b0;
  event        chk_ev;
  int          n_checks = 0;
  int          n_errors = 0;

  // Single monitor: strobe events at the falling edge, queued checks when requested.
  initial begin
    chk_t        c;
    logic [31:0] act;
    logic [31:0] e;
    forever begin
      @(chk_ev or negedge clk);
      if (clk == 1'b0) begin
        if (sb_en && sample_strobe) begin
          n_checks++;
          if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL strobe_unexpected: out_port 0x%08h, required no strobe", out_port);
          end else begin
            e = sb_q.pop_front();
            if (out_port !== e) begin
              n_errors++;
              $display("FAIL strobe_sample: out_port 0x%08h, required 0x%08h", out_port, e);
            end else begin
              $display("strobe sample 0x%08h ok", out_port);
            end
          end
        end
      end else if (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        case (c.sel)
          S_RDATA:  act = readdata;
          S_OUT:    act = out_port;
          S_IRQ:    act = {31'd0, irq};
          S_STROBE: act = {31'd0, sample_strobe};
          default:  act = sb_q.size();
        endcase
        n_checks++;
        if (act !== c.exp) begin
          n_errors++;
          $display("FAIL %s: got 0x%08h, required 0x%08h", c.name, act, c.exp);
        end else begin
          $display("check %s = 0x%08h ok", c.name, act);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input int sel, input logic [1:0] a, input logic [31:0] exp, input string name);
    chk_t c;
    address = a;
    #1;
    c.sel = sel;
    c.exp = exp;
    c.name = name;
    chk_q.push_back(c);
    ->chk_ev;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  task automatic wr2(input logic [1:0] a0, input logic [31:0] d0,
                     input logic [1:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a0;
    writedata  = d0;
    @(posedge clk);
    #1;
    address    = a1;
    writedata  = d1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    $display("write addr=%0d data=0x%08h then addr=%0d data=0x%08h", a0, d0, a1, d1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset applied");
  endtask

  task automatic chk_reset_state(input string tag);
    chk(S_OUT,    A_DATA, 32'h0,          {tag, "_out_port"});
    chk(S_RDATA,  A_DATA, 32'h0,          {tag, "_rd_data"});
    chk(S_STROBE, A_DATA, 32'h0,          {tag, "_strobe"});
    chk(S_IRQ,    A_DATA, 32'h0,          {tag, "_irq"});
    chk(S_RDATA,  A_STAT, 32'h0000_0001,  {tag, "_status"});
    chk(S_RDATA,  A_CTRL, 32'h0,          {tag, "_control"});
    chk(S_RDATA,  A_DIV,  32'd1041,       {tag, "_divider"});
  endtask

  initial begin
    logic [31:0] exp_out;
    logic [31:0] exp_stat;

    // Reset values
    do_reset();
    chk_reset_state("rst");

    // Two samples at DIVIDER=3: pops every 4 cycles
    wr(A_DIV, 32'd3);
    wr(A_DATA, 32'h11);
    wr(A_DATA, 32'h22);
    chk(S_RDATA, A_STAT, 32'h0002_0000, "seq_status_l2");
    sb_q.push_back(32'h11);
    sb_q.push_back(32'h22);
    sb_en = 1'b1;
    wr(A_CTRL, 32'h1);
    for (int c = 1; c <= 8; c++) begin
      idle(1);
      exp_out  = (c < 4) ? 32'h0 : ((c < 8) ? 32'h11 : 32'h22);
      exp_stat = (c < 4) ? 32'h0002_0000 : ((c < 8) ? 32'h0001_0000 : 32'h0000_0001);
      chk(S_OUT,    A_DATA, exp_out, $sformatf("seq_out_c%0d", c));
      chk(S_STROBE, A_DATA, {31'd0, (c == 4) || (c == 8)}, $sformatf("seq_strobe_c%0d", c));
      chk(S_RDATA,  A_STAT, exp_stat, $sformatf("seq_status_c%0d", c));
    end
    wr(A_CTRL, 32'h0);
    idle(6);
    sb_en = 1'b0;
    chk(S_SBQ, A_DATA, 32'd0, "seq_strobes_left");

    // Overflow: 17 writes into 16 entries, 17th value never comes out
    do_reset();
    for (int i = 0; i < 17; i++) wr(A_DATA, 32'h100 + i);
    chk(S_RDATA, A_STAT, 32'h0010_000A, "ovf_status_full");
    wr(A_DIV, 32'd0);
    wr(A_CTRL, 32'h1);
    for (int c = 1; c <= 17; c++) begin
      idle(1);
      exp_out = 32'h100 + ((c <= 16) ? (c - 1) : 15);
      chk(S_OUT, A_DATA, exp_out, $sformatf("ovf_pop_c%0d", c));
    end
    wr(A_CTRL, 32'h0);
    chk(S_RDATA, A_STAT, 32'h0000_000D, "ovf_status_drained");
    wr(A_STAT, 32'hC);
    chk(S_RDATA, A_STAT, 32'h0000_0001, "ovf_status_cleared");

    // Underrun on an empty FIFO at DIVIDER=0
    do_reset();
    wr(A_DIV, 32'd0);
    wr(A_CTRL, 32'h1);
    idle(1);
    chk(S_RDATA,  A_STAT, 32'h0000_0005, "udr_status_set");
    chk(S_STROBE, A_DATA, 32'h1,         "udr_strobe");
    chk(S_OUT,    A_DATA, 32'h0,         "udr_out_held");
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h4);
    chk(S_RDATA, A_STAT, 32'h0000_0001, "udr_status_cleared");
    chk(S_RDATA, A_DATA, 32'h0,         "udr_rd_data");

    // Push into a full FIFO on the same cycle as a tick
    do_reset();
    wr(A_DIV, 32'd100);
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 16; i++) wr(A_DATA, 32'h200 + i);
    chk(S_RDATA, A_STAT, 32'h0010_0002, "fullpop_status_before");
    wr2(A_DIV, 32'd0, A_DATA, 32'h2AA);
    chk(S_RDATA,  A_STAT, 32'h0010_0002, "fullpop_status_after");
    chk(S_OUT,    A_DATA, 32'h200,       "fullpop_out");
    chk(S_STROBE, A_DATA, 32'h1,         "fullpop_strobe");
    wr(A_CTRL, 32'h0);
    chk(S_RDATA, A_STAT, 32'h000E_0000, "fullpop_status_l14");
    chk(S_OUT,   A_DATA, 32'h202,       "fullpop_out_after");

    // Flush with enable and irq_en, then refill to cross the watermark
    do_reset();
    for (int i = 0; i < 10; i++) wr(A_DATA, 32'h300 + i);
    wr(A_DIV, 32'd0);
    wr(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h0);
    wr(A_DIV, 32'd1000);
    chk(S_RDATA, A_STAT, 32'h0008_0000, "irq_status_l8");
    chk(S_OUT,   A_DATA, 32'h301,       "irq_out_before");
    wr(A_CTRL, 32'h7);
    chk(S_RDATA, A_STAT, 32'h0000_0001, "irq_status_flushed");
    chk(S_OUT,   A_DATA, 32'h301,       "irq_out_kept");
    chk(S_RDATA, A_CTRL, 32'h0000_0005, "irq_control_rd");
    chk(S_IRQ,   A_DATA, 32'h0,         "irq_not_yet");
    idle(1);
    chk(S_IRQ, A_DATA, 32'h1, "irq_asserted");
    for (int i = 0; i < 4; i++) wr(A_DATA, 32'h310 + i);
    idle(1);
    chk(S_IRQ, A_DATA, 32'h1, "irq_at_wm");
    wr(A_DATA, 32'h314);
    idle(1);
    chk(S_IRQ,   A_DATA, 32'h0,         "irq_above_wm");
    chk(S_RDATA, A_STAT, 32'h0005_0000, "irq_status_l5");

    // Reset mid-stream while a tick and a push land in the same cycle
    do_reset();
    wr(A_DATA, 32'h400);
    wr(A_DATA, 32'h401);
    wr(A_DATA, 32'h402);
    wr(A_DIV, 32'd0);
    wr(A_CTRL, 32'h5);
    @(posedge clk);
    #1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = A_DATA;
    writedata  = 32'h4FF;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset      = 1'b0;
    $display("mid-stream reset with push 0x000004ff");
    chk_reset_state("midrst");

    #10;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
